// File: rtl/memory_access_lsu_if.sv
// Request/response bundle between the pipeline MEM stage and the load/store unit.
// The slave modport is the LSU side; the master modport is the requesting side.
interface memory_access_lsu_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            we_i;
    logic            re_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] address_i;
    logic [XLEN-1:0] write_data_i;
    logic [XLEN-1:0] npc_i;
    logic [XLEN-1:0] alu_out_i;
    logic            cond_i;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] lmd_o;
    logic [XLEN-1:0] condpc_o;
    logic            err_o;

    modport master (
        output valid_i, we_i, re_i, funct3_i, address_i, write_data_i,
               npc_i, alu_out_i, cond_i,
        input  ready_o, valid_o, lmd_o, condpc_o, err_o
    );

    modport slave (
        input  valid_i, we_i, re_i, funct3_i, address_i, write_data_i,
               npc_i, alu_out_i, cond_i,
        output ready_o, valid_o, lmd_o, condpc_o, err_o
    );
endinterface

// File: rtl/memory_access_lsu.sv
// RV32 load/store unit with an internal word-organised data memory, optional
// wait states, byte-lane stores, sign/zero-extended loads and next-PC select.
module memory_access_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_access_lsu_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;
    localparam logic [2:0] CNT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic            w_accept, w_fire;

    logic            w_we, w_re, w_cond;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_addr, w_wdata, w_npc, w_alu;

    logic [1:0]      w_off;
    logic [AW-1:0]   w_idx;
    logic            w_illegal, w_misal, w_err, w_store, w_load;
    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_wrep, w_rdata, w_rshift, w_lmd, w_condpc;
    logic            w_unused_addr;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            r_valid, r_err;
    logic [XLEN-1:0] r_lmd, r_condpc;

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  load_extend = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  load_extend = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  load_extend = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  load_extend = {{(XLEN-16){1'b0}}, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    assign bus.ready_o = (r_state == IDLE);
    assign w_accept    = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // w_fire marks the edge at which the memory access and result capture happen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_fire = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = IDLE;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign w_we    = bus.we_i;
            assign w_re    = bus.re_i;
            assign w_cond  = bus.cond_i;
            assign w_f3    = bus.funct3_i;
            assign w_addr  = bus.address_i;
            assign w_wdata = bus.write_data_i;
            assign w_npc   = bus.npc_i;
            assign w_alu   = bus.alu_out_i;
        end else begin : g_capture
            logic            r_we, r_re, r_cond;
            logic [2:0]      r_f3;
            logic [XLEN-1:0] r_addr, r_wdata, r_npc, r_alu;
            // Request is held while the access waits out its memory cycles.
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_we    <= bus.we_i;
                    r_re    <= bus.re_i;
                    r_cond  <= bus.cond_i;
                    r_f3    <= bus.funct3_i;
                    r_addr  <= bus.address_i;
                    r_wdata <= bus.write_data_i;
                    r_npc   <= bus.npc_i;
                    r_alu   <= bus.alu_out_i;
                end
            end
            assign w_we    = r_we;
            assign w_re    = r_re;
            assign w_cond  = r_cond;
            assign w_f3    = r_f3;
            assign w_addr  = r_addr;
            assign w_wdata = r_wdata;
            assign w_npc   = r_npc;
            assign w_alu   = r_alu;
        end
    endgenerate

    assign w_off         = w_addr[1:0];
    assign w_idx         = w_addr[AW+1:2];
    assign w_unused_addr = ^w_addr[XLEN-1:AW+2];

    // BU/HU only make sense for loads, so they are rejected on stores.
    always_comb begin
        w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11) || (w_we && w_f3[2]);
        w_misal   = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                    ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
        w_err     = (w_we || w_re) && (w_illegal || w_misal);
        w_store   = w_fire && w_we && !w_err;
        w_load    = w_re && !w_we && !w_err;
        case (w_f3[1:0])
            2'b00:   w_mask = NB'(1) << w_off;
            2'b01:   w_mask = NB'(3) << {w_off[1], 1'b0};
            default: w_mask = '1;
        endcase
        case (w_f3[1:0])
            2'b00:   w_wrep = {NB{w_wdata[7:0]}};
            2'b01:   w_wrep = {(NB/2){w_wdata[15:0]}};
            default: w_wrep = w_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int l = 0; l < NB; l++) begin
                if (w_mask[l]) r_mem[w_idx][8*l +: 8] <= w_wrep[8*l +: 8];
            end
        end
    end

    assign w_rdata  = r_mem[w_idx];
    assign w_rshift = w_rdata >> {w_off, 3'b000};
    assign w_lmd    = w_load ? load_extend(w_f3, w_rshift) : '0;
    assign w_condpc = w_cond ? w_alu : w_npc;

    // Result registers hold their value between valid_o pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_lmd    <= '0;
            r_condpc <= '0;
        end else begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_err    <= w_err;
                r_lmd    <= w_lmd;
                r_condpc <= w_condpc;
            end
        end
    end

    assign bus.valid_o  = r_valid;
    assign bus.err_o    = r_err;
    assign bus.lmd_o    = r_lmd;
    assign bus.condpc_o = r_condpc;
endmodule

// File: tb/tb_memory_access_lsu.sv
// Directed bench: one LSU with no wait states and one with two wait states,
// sharing clock and reset.
module tb_memory_access_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    memory_access_lsu_if #(.XLEN(32)) b0 ();
    memory_access_lsu_if #(.XLEN(32)) b2 ();

    memory_access_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    memory_access_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2));

    // Zero-wait request: accept on the next edge, result is sampled right after it.
    task automatic drive0(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        b0.valid_i = 1'b1; b0.we_i = we; b0.re_i = re; b0.funct3_i = f3;
        b0.address_i = a; b0.write_data_i = wd;
        @(posedge clk); #1;
        b0.valid_i = 1'b0;
    endtask

    // Wait-state request: returns the cycle count from accept to valid_o (bounded).
    task automatic go2(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output int lat);
        b2.valid_i = 1'b1; b2.we_i = we; b2.re_i = re; b2.funct3_i = f3;
        b2.address_i = a; b2.write_data_i = wd;
        @(posedge clk); #1;
        b2.valid_i = 1'b0;
        lat = 1;
        while (b2.valid_o !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (b0.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready0 got=%b want=1", b0.ready_o); end
        total++; if (b0.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%b want=0", b0.valid_o); end
        total++; if (b0.lmd_o !== 32'h0) begin bad++; $display("FAIL rst_lmd0 got=%h want=0", b0.lmd_o); end
        total++; if (b0.condpc_o !== 32'h0) begin bad++; $display("FAIL rst_condpc0 got=%h want=0", b0.condpc_o); end
        total++; if (b0.err_o !== 1'b0) begin bad++; $display("FAIL rst_err0 got=%b want=0", b0.err_o); end
        total++; if (b2.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready2 got=%b want=1", b2.ready_o); end
        total++; if (b2.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid2 got=%b want=0", b2.valid_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        drive0(1'b1, 1'b0, 3'b010, 32'h0, 32'hF000_0000);
        total++; if (b0.valid_o !== 1'b1) begin bad++; $display("FAIL sw0_valid got=%b want=1", b0.valid_o); end
        total++; if (b0.err_o !== 1'b0 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL sw0_res got err=%b lmd=%h want err=0 lmd=0", b0.err_o, b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
        total++; if (b0.valid_o !== 1'b1) begin bad++; $display("FAIL lw0_valid got=%b want=1", b0.valid_o); end
        total++; if (b0.lmd_o !== 32'hF000_0000) begin bad++; $display("FAIL lw0_lmd got=%h want=f0000000", b0.lmd_o); end
        total++; if (b0.err_o !== 1'b0) begin bad++; $display("FAIL lw0_err got=%b want=0", b0.err_o); end
        @(posedge clk); #1;
        total++; if (b0.valid_o !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b want=0", b0.valid_o); end
        total++; if (b0.lmd_o !== 32'hF000_0000) begin bad++; $display("FAIL lmd_hold got=%h want=f0000000", b0.lmd_o); end
    endtask

    task automatic test_byte_lanes;
        drive0(1'b1, 1'b0, 3'b010, 32'd8, 32'h1122_3344);
        drive0(1'b1, 1'b0, 3'b000, 32'd11, 32'h0000_0080);
        drive0(1'b0, 1'b1, 3'b000, 32'd11, 32'h0);
        total++; if (b0.lmd_o !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb11 got=%h want=ffffff80", b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b100, 32'd11, 32'h0);
        total++; if (b0.lmd_o !== 32'h0000_0080) begin bad++; $display("FAIL lbu11 got=%h want=00000080", b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'd8, 32'h0);
        total++; if (b0.lmd_o !== 32'h8022_3344) begin bad++; $display("FAIL lw8 got=%h want=80223344", b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b001, 32'd10, 32'h0);
        total++; if (b0.lmd_o !== 32'hFFFF_8022) begin bad++; $display("FAIL lh10 got=%h want=ffff8022", b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b101, 32'd10, 32'h0);
        total++; if (b0.lmd_o !== 32'h0000_8022) begin bad++; $display("FAIL lhu10 got=%h want=00008022", b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b000, 32'd8, 32'h0);
        total++; if (b0.lmd_o !== 32'h0000_0044) begin bad++; $display("FAIL lb8 got=%h want=00000044", b0.lmd_o); end
    endtask

    task automatic test_misaligned;
        drive0(1'b1, 1'b0, 3'b010, 32'd4, 32'hAAAA_AAAA);
        drive0(1'b1, 1'b0, 3'b001, 32'd5, 32'h0000_1234);
        total++; if (b0.err_o !== 1'b1 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL sh5 got err=%b lmd=%h want err=1 lmd=0", b0.err_o, b0.lmd_o); end
        drive0(1'b1, 1'b0, 3'b100, 32'd4, 32'h0000_0055);
        total++; if (b0.err_o !== 1'b1) begin bad++; $display("FAIL sbu_illegal got=%b want=1", b0.err_o); end
        drive0(1'b0, 1'b1, 3'b011, 32'd4, 32'h0);
        total++; if (b0.err_o !== 1'b1 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL f3_011 got err=%b lmd=%h want err=1 lmd=0", b0.err_o, b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'd6, 32'h0);
        total++; if (b0.err_o !== 1'b1 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL lw6 got err=%b lmd=%h want err=1 lmd=0", b0.err_o, b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'd4, 32'h0);
        total++; if (b0.err_o !== 1'b0 || b0.lmd_o !== 32'hAAAA_AAAA) begin bad++; $display("FAIL lw4 got err=%b lmd=%h want err=0 lmd=aaaaaaaa", b0.err_o, b0.lmd_o); end
    endtask

    task automatic test_condpc;
        b0.npc_i = 32'd4; b0.alu_out_i = 32'd40; b0.cond_i = 1'b0;
        drive0(1'b0, 1'b0, 3'b010, 32'd8, 32'h0);
        total++; if (b0.condpc_o !== 32'd4) begin bad++; $display("FAIL condpc_nt got=%0d want=4", b0.condpc_o); end
        total++; if (b0.valid_o !== 1'b1 || b0.err_o !== 1'b0 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL passthru got v=%b err=%b lmd=%h want v=1 err=0 lmd=0", b0.valid_o, b0.err_o, b0.lmd_o); end
        b0.cond_i = 1'b1;
        drive0(1'b0, 1'b0, 3'b111, 32'd3, 32'h0);
        total++; if (b0.condpc_o !== 32'd40) begin bad++; $display("FAIL condpc_t got=%0d want=40", b0.condpc_o); end
        total++; if (b0.err_o !== 1'b0) begin bad++; $display("FAIL passthru_err got=%b want=0", b0.err_o); end
        b0.cond_i = 1'b0; b0.npc_i = 32'h0; b0.alu_out_i = 32'h0;
    endtask

    task automatic test_we_re_wrap;
        drive0(1'b1, 1'b1, 3'b010, 32'd12, 32'h1234_5678);
        total++; if (b0.err_o !== 1'b0 || b0.lmd_o !== 32'h0) begin bad++; $display("FAIL we_re got err=%b lmd=%h want err=0 lmd=0", b0.err_o, b0.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'd12, 32'h0);
        total++; if (b0.lmd_o !== 32'h1234_5678) begin bad++; $display("FAIL we_re_lw got=%h want=12345678", b0.lmd_o); end
        drive0(1'b1, 1'b0, 3'b010, 32'hFFFF_0010, 32'hCAFE_BABE);
        drive0(1'b0, 1'b1, 3'b010, 32'h0000_1010, 32'h0);
        total++; if (b0.lmd_o !== 32'hCAFE_BABE) begin bad++; $display("FAIL wrap got=%h want=cafebabe", b0.lmd_o); end
    endtask

    task automatic test_back_to_back;
        b0.valid_i = 1'b1; b0.we_i = 1'b1; b0.re_i = 1'b0; b0.funct3_i = 3'b010;
        b0.address_i = 32'd20; b0.write_data_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        total++; if (b0.valid_o !== 1'b1 || b0.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_first got v=%b rdy=%b want 1 1", b0.valid_o, b0.ready_o); end
        b0.we_i = 1'b0; b0.re_i = 1'b1;
        @(posedge clk); #1;
        b0.valid_i = 1'b0;
        total++; if (b0.valid_o !== 1'b1 || b0.lmd_o !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_load got v=%b lmd=%h want v=1 lmd=0badf00d", b0.valid_o, b0.lmd_o); end
    endtask

    task automatic test_wait_states;
        int lat;
        go2(1'b1, 1'b0, 3'b010, 32'd0, 32'h0, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL ws_sw0_lat got=%0d want=3", lat); end
        b2.valid_i = 1'b1; b2.we_i = 1'b0; b2.re_i = 1'b1; b2.funct3_i = 3'b010;
        b2.address_i = 32'd0;
        @(posedge clk); #1;
        b2.valid_i = 1'b0;
        total++; if (b2.ready_o !== 1'b0 || b2.valid_o !== 1'b0) begin bad++; $display("FAIL ws_c1 got rdy=%b v=%b want 0 0", b2.ready_o, b2.valid_o); end
        @(posedge clk); #1;
        total++; if (b2.ready_o !== 1'b0 || b2.valid_o !== 1'b0) begin bad++; $display("FAIL ws_c2 got rdy=%b v=%b want 0 0", b2.ready_o, b2.valid_o); end
        @(posedge clk); #1;
        total++; if (b2.ready_o !== 1'b1 || b2.valid_o !== 1'b1) begin bad++; $display("FAIL ws_c3 got rdy=%b v=%b want 1 1", b2.ready_o, b2.valid_o); end
        total++; if (b2.lmd_o !== 32'h0 || b2.err_o !== 1'b0) begin bad++; $display("FAIL ws_lw0 got lmd=%h err=%b want 0 0", b2.lmd_o, b2.err_o); end
        go2(1'b1, 1'b0, 3'b010, 32'd4, 32'h0000_0077, lat);
        go2(1'b0, 1'b1, 3'b010, 32'd4, 32'h0, lat);
        total++; if (lat !== 3 || b2.lmd_o !== 32'h0000_0077) begin bad++; $display("FAIL ws_lw4 got lat=%0d lmd=%h want 3 00000077", lat, b2.lmd_o); end
    endtask

    task automatic test_reset_during_wait;
        int lat;
        b2.valid_i = 1'b1; b2.we_i = 1'b1; b2.re_i = 1'b0; b2.funct3_i = 3'b010;
        b2.address_i = 32'd0; b2.write_data_i = 32'h5;
        @(posedge clk); #1;
        b2.valid_i = 1'b0;
        total++; if (b2.ready_o !== 1'b0) begin bad++; $display("FAIL rdw_inwait got=%b want=0", b2.ready_o); end
        #2 rst = 1'b1;
        #1;
        total++; if (b2.ready_o !== 1'b1 || b2.valid_o !== 1'b0) begin bad++; $display("FAIL rdw_async got rdy=%b v=%b want 1 0", b2.ready_o, b2.valid_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (b2.valid_o !== 1'b0) begin bad++; $display("FAIL rdw_novalid got=%b want=0", b2.valid_o); end
        go2(1'b0, 1'b1, 3'b010, 32'd0, 32'h0, lat);
        total++; if (lat !== 3 || b2.lmd_o !== 32'h0) begin bad++; $display("FAIL rdw_lw0 got lat=%0d lmd=%h want 3 00000000", lat, b2.lmd_o); end
        drive0(1'b0, 1'b1, 3'b010, 32'd8, 32'h0);
        total++; if (b0.lmd_o !== 32'h8022_3344) begin bad++; $display("FAIL mem_keep got=%h want=80223344", b0.lmd_o); end
    endtask

    initial begin
        b0.valid_i = 1'b0; b0.we_i = 1'b0; b0.re_i = 1'b0; b0.funct3_i = 3'b010;
        b0.address_i = '0; b0.write_data_i = '0; b0.npc_i = '0; b0.alu_out_i = '0; b0.cond_i = 1'b0;
        b2.valid_i = 1'b0; b2.we_i = 1'b0; b2.re_i = 1'b0; b2.funct3_i = 3'b010;
        b2.address_i = '0; b2.write_data_i = '0; b2.npc_i = '0; b2.alu_out_i = '0; b2.cond_i = 1'b0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_misaligned();
        test_condpc();
        test_we_re_wrap();
        test_back_to_back();
        test_wait_states();
        test_reset_during_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_access_lsu.md
MEMORY_ACCESS_LSU -- requirements
Module: memory_access_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning internal data memory size in XLEN-bit words (power of two).
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, meaning extra memory cycles per access (0..7).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  in  1  clock, all state on rising edge.
REQ-006 Port: rst  in  1  asynchronous active-high reset.
REQ-007 Port: valid_i  in  1  request present.
REQ-008 Port: we_i  in  1  store request.
REQ-009 Port: re_i  in  1  load request.
REQ-010 Port: funct3_i  in  3  RV32 size code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 Port: address_i  in  XLEN  byte address (ALU result).
REQ-012 Port: write_data_i  in  XLEN  store data, low-order bytes used for B/H.
REQ-013 Port: npc_i  in  XLEN  sequential next PC.
REQ-014 Port: alu_out_i  in  XLEN  branch/jump target.
REQ-015 Port: cond_i  in  1  branch taken.
REQ-016 Port: ready_o  out  1  request accepted this cycle when high with valid_i.
REQ-017 Port: valid_o  out  1  one-cycle result pulse.
REQ-018 Port: lmd_o  out  XLEN  load memory data, extended.
REQ-019 Port: condpc_o  out  XLEN  selected next PC.
REQ-020 Port: err_o  out  1  misaligned access or illegal funct3.

Function
REQ-021 Accept SHALL occur at a rising edge where valid_i and ready_o are both high; all inputs are captured at that edge.
REQ-022 FSM SHALL have states IDLE and WAIT; ready_o = 1 exactly in IDLE.
REQ-023 WAIT_STATES=0: access performed at the accept edge, FSM stays IDLE, back-to-back accepts allowed.
REQ-024 WAIT_STATES=N>0: accept moves to WAIT with counter N-1; counter decrements each edge; at the edge with counter 0 the access is performed and FSM returns to IDLE; ready_o is low for exactly N cycles.
REQ-025 valid_o SHALL be high for exactly the one cycle following the access edge (latency N+1 cycles from accept); lmd_o, condpc_o and err_o are registered and hold until the next valid_o.
REQ-026 condpc_o SHALL be alu_out_i if cond_i else npc_i, as captured at accept.
REQ-027 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (wrap-around).
REQ-028 Stores SHALL write only enabled byte lanes: B lane address[1:0], H lanes address[1]*2 and +1, W all lanes.
REQ-029 Loads SHALL select the same lanes; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-030 Misaligned (H with address[0]=1; W with address[1:0]!=0) or illegal funct3 (011, 110, 111, or BU/HU on a store) SHALL suppress the memory write, give lmd_o=0 and err_o=1, with normal latency.
REQ-031 we_i and re_i both high SHALL perform the store only, lmd_o=0, err_o=0.
REQ-032 Neither we_i nor re_i SHALL pass through: no memory access, lmd_o=0, err_o=0, condpc_o valid, normal latency.
REQ-033 A load accepted after a store SHALL return the stored data (write visible from the edge after the store's access edge).

Reset
REQ-034 rst high SHALL immediately force state IDLE, counter 0, valid_o=0, lmd_o=0, condpc_o=0, err_o=0; ready_o=1.
REQ-035 Reset during WAIT SHALL abandon the pending access; a pending store is not committed.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-037 SW 0xF0000000 @0 then LW @0 (N=0) -> second valid_o gives lmd_o=0xF0000000, err_o=0.
REQ-038 SW 0x11223344 @8, SB 0x80 @11, LB @11, LBU @11, LW @8 -> 0xFFFFFF80, 0x00000080, 0x80223344.
REQ-039 SW 0xAAAAAAAA @4, then SH @5 -> err_o=1, lmd_o=0; then LW @4 -> 0xAAAAAAAA (unchanged).
REQ-040 npc_i=4, alu_out_i=40, cond_i=0 -> condpc_o=4; with cond_i=1 -> condpc_o=40.
REQ-041 WAIT_STATES=2: accept LW -> ready_o low 2 cycles, valid_o high the 3rd cycle after accept, ready_o high again.
REQ-042 WAIT_STATES=2: SW 0x5 @0 over prior 0x0, assert rst during WAIT, then LW @0 -> lmd_o=0x0.
